// File: rtl/fp_adder_arbiter_if.sv
// Bus bundle between the compute clients / shared adder and fp_adder_arbiter.
//
// Handshake: a requester holds req_valid[i] and its operands stable until it
// sees req_ready[i] high; the transfer happens on the rising edge where both
// are high. Results carry no backpressure: rsp_valid is a one-cycle one-hot
// pulse that the owning requester must consume in that same cycle.
interface fp_adder_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // requester side
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_add_sub;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;
   logic                  busy;

   // shared adder side
   logic                  adder_add_sub_bit;
   logic [31:0]           adder_inputA;
   logic [31:0]           adder_inputB;
   logic [31:0]           adder_outputC;

   // debug visibility of the scheduler state (4-bit count per requester)
   logic [PtrW-1:0]       dbgRrPtr;
   logic [4*NUM_REQ-1:0]  dbgOutstanding;

   // clients + adder model drive these
   modport master (
      output req_valid, req_add_sub, req_a, req_b, adder_outputC,
      input  req_ready, rsp_valid, rsp_data, busy,
             adder_add_sub_bit, adder_inputA, adder_inputB,
             dbgRrPtr, dbgOutstanding
   );

   // the arbiter drives these
   modport slave (
      input  req_valid, req_add_sub, req_a, req_b, adder_outputC,
      output req_ready, rsp_valid, rsp_data, busy,
             adder_add_sub_bit, adder_inputA, adder_inputB,
             dbgRrPtr, dbgOutstanding
   );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin scheduler sharing one pipelined single-precision adder among
// NUM_REQ requesters. The winning operation is registered onto the adder
// inputs, a tag pipeline follows it through the adder, and the result is
// returned as a one-hot pulse to the requester that issued it. Operand and
// result bits pass through untouched.
module fp_adder_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ADDER_LATENCY = 3,
   parameter int MAX_OUT       = 4
) (
   input logic               clock_in,
   input logic               reset_n,
   fp_adder_arbiter_if.slave bus
);

   localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CntW = $clog2(MAX_OUT + 1);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);
   localparam logic [PtrW:0]   NumReqW = (PtrW + 1)'(NUM_REQ);
   localparam logic [CntW-1:0] MaxOutW = CntW'(MAX_OUT);

   logic [PtrW-1:0]    rrPtr;
   logic [CntW-1:0]    outstanding [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic               grantValid;
   logic [PtrW-1:0]    grantIdx;
   logic [PtrW:0]      candIdx;
   logic [NUM_REQ-1:0] grantOneHot;

   logic [31:0]        inputA;
   logic [31:0]        inputB;
   logic               addSub;

   // Entry 0 sits beside the adder input register (loaded on the transfer
   // edge); entries 1..ADDER_LATENCY shadow the adder's internal stages, so
   // the last entry lines up with a valid adder_outputC.
   logic [ADDER_LATENCY:0] tagValid;
   logic [PtrW-1:0]        tagId [ADDER_LATENCY+1];
   logic                   retireValid;
   logic [PtrW-1:0]        retireId;
   logic [NUM_REQ-1:0]     retireOneHot;

   logic [NUM_REQ-1:0] rspValid;
   logic [31:0]        rspData;

   // A requester may compete only while it has room for another in-flight op.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.req_valid[i] && (outstanding[i] < MaxOutW);
      end
   end

   // First eligible requester at or after rrPtr, wrapping; nothing while in reset.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      candIdx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         candIdx = {1'b0, rrPtr} + (PtrW + 1)'(k);
         if (candIdx >= NumReqW) begin
            candIdx = candIdx - NumReqW;
         end
         if (!grantValid && eligible[candIdx[PtrW-1:0]]) begin
            grantValid = 1'b1;
            grantIdx   = candIdx[PtrW-1:0];
         end
      end
      if (!reset_n) begin
         grantValid = 1'b0;
      end
   end

   // Grant and retire decoded to one-hot vectors for the ready and count logic.
   always_comb begin
      grantOneHot  = grantValid  ? (NUM_REQ'(1) << grantIdx) : '0;
      retireOneHot = retireValid ? (NUM_REQ'(1) << retireId) : '0;
   end

   assign retireValid = tagValid[ADDER_LATENCY];
   assign retireId    = tagId[ADDER_LATENCY];

   // Pointer moves past the winner on every transfer and holds on idle cycles.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         rrPtr <= '0;
      end else if (grantValid) begin
         rrPtr <= (grantIdx == LastIdx) ? '0 : grantIdx + 1'b1;
      end
   end

   // Adder input register loads the winner's fields and holds otherwise.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         inputA <= '0;
         inputB <= '0;
         addSub <= 1'b0;
      end else if (grantValid) begin
         inputA <= bus.req_a[{grantIdx, 5'b0} +: 32];
         inputB <= bus.req_b[{grantIdx, 5'b0} +: 32];
         addSub <= bus.req_add_sub[grantIdx];
      end
   end

   // Tag pipeline: a valid tag per transfer, a bubble on idle cycles.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         tagValid <= '0;
         for (int s = 0; s <= ADDER_LATENCY; s++) begin
            tagId[s] <= '0;
         end
      end else begin
         tagValid <= {tagValid[ADDER_LATENCY-1:0], grantValid};
         tagId[0] <= grantIdx;
         for (int s = 1; s <= ADDER_LATENCY; s++) begin
            tagId[s] <= tagId[s-1];
         end
      end
   end

   // Capture the adder result for the retiring tag and pulse its owner.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         rspValid <= '0;
         rspData  <= '0;
      end else begin
         rspValid <= retireOneHot;
         if (retireValid) begin
            rspData <= bus.adder_outputC;
         end
      end
   end

   // Per-requester in-flight count; issue and retire on one edge cancel out.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            outstanding[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grantOneHot[i] && !retireOneHot[i] && (outstanding[i] != MaxOutW)) begin
               outstanding[i] <= outstanding[i] + 1'b1;
            end else if (!grantOneHot[i] && retireOneHot[i] && (outstanding[i] != '0)) begin
               outstanding[i] <= outstanding[i] - 1'b1;
            end
         end
      end
   end

   // Debug view of the counts, each widened to a 4-bit lane.
   always_comb begin
      bus.dbgOutstanding = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.dbgOutstanding[4*i +: 4] = 4'(outstanding[i]);
      end
   end

   assign bus.req_ready         = grantOneHot;
   assign bus.adder_inputA      = inputA;
   assign bus.adder_inputB      = inputB;
   assign bus.adder_add_sub_bit = addSub;
   assign bus.rsp_valid         = rspValid;
   assign bus.rsp_data          = rspData;
   assign bus.busy              = (|tagValid) || (|rspValid);
   assign bus.dbgRrPtr          = rrPtr;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter with a behavioural adder, a scoreboard
// of expected {id, result} pairs and a monitor that pops it on every pulse.
module tb_fp_adder_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int ADDER_LATENCY = 3;
   localparam int MAX_OUT       = 4;
   localparam int W             = 34;

   logic clockIn = 1'b0;
   logic resetN  = 1'b0;

   fp_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   fp_adder_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ADDER_LATENCY(ADDER_LATENCY),
      .MAX_OUT(MAX_OUT)
   ) dut (
      .clock_in(clockIn),
      .reset_n(resetN),
      .bus(bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clockIn = ~clockIn;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural adder (exact for the values used) ----------------
   function automatic real sp2real(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'b0) d = {f[31], 63'b0};
      else d = {f[31], 11'({3'b0, f[30:23]} + 11'd896), f[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'b0) return {d[63], 31'b0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   logic [31:0] addPipe [ADDER_LATENCY];

   always @(posedge clockIn) begin
      addPipe[0] <= real2sp(bus.adder_add_sub_bit ?
                            sp2real(bus.adder_inputA) - sp2real(bus.adder_inputB) :
                            sp2real(bus.adder_inputA) + sp2real(bus.adder_inputB));
      for (int s = 1; s < ADDER_LATENCY; s++) addPipe[s] <= addPipe[s-1];
   end

   assign bus.adder_outputC = addPipe[ADDER_LATENCY-1];

   // ---------------- checking ----------------
   int checkCount  = 0;
   int passCount   = 0;
   int acceptCount = 0;
   int resultCount = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------- scoreboard + monitor ----------------
   logic [W-1:0]       exp_q[$];
   int                 grantLog[$];
   logic [31:0]        reqExp [NUM_REQ];
   int                 modelOut [NUM_REQ];
   logic [NUM_REQ-1:0] pendAcc;
   logic [W-1:0]       monEntry;

   always @(negedge clockIn) begin
      if (!resetN) begin
         exp_q.delete();
         pendAcc = '0;
         for (int i = 0; i < NUM_REQ; i++) modelOut[i] = 0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) if (pendAcc[i]) modelOut[i]++;
         if (bus.rsp_valid != '0) begin
            check("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
               monEntry = exp_q.pop_front();
               check("rsp_id", 64'(bus.rsp_valid), 64'(4'b0001 << monEntry[33:32]));
               check("rsp_data", 64'(bus.rsp_data), 64'(monEntry[31:0]));
               resultCount++;
               modelOut[monEntry[33:32]]--;
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            check("outstanding", 64'(bus.dbgOutstanding[4*i +: 4]), 64'(modelOut[i]));
            if (modelOut[i] >= MAX_OUT) check("cap_ready_low", 64'(bus.req_ready[i]), 64'd0);
         end
         check("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
         pendAcc = bus.req_valid & bus.req_ready;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pendAcc[i]) begin
               exp_q.push_back({2'(i), reqExp[i]});
               acceptCount++;
               grantLog.push_back(i);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic setReq(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] expD);
      bus.req_a[id*32 +: 32] = a;
      bus.req_b[id*32 +: 32] = b;
      bus.req_add_sub[id]    = sub;
      reqExp[id]             = expD;
      bus.req_valid[id]      = 1'b1;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < 60) begin
         @(posedge clockIn);
         #1;
         n++;
      end
      check(tag, 64'(n < 60), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] opA [4]      = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   logic [31:0] rrExp [4]    = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
   logic [31:0] bubExp [4]   = '{32'h40000000, 32'h3F800000, 32'h40800000, 32'h40400000};
   int          rrOrder [5]  = '{0, 1, 2, 3, 0};
   logic        capRdy [12]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic        readyLog [12];
   int          a0, r0, n, maxOut;

   initial begin
      bus.req_valid   = '0;
      bus.req_add_sub = '0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      for (int i = 0; i < NUM_REQ; i++) reqExp[i] = '0;

      // reset state, with all requesters asserting valid
      bus.req_valid = '1;
      repeat (3) @(posedge clockIn);
      #1;
      check("rst_inA", 64'(bus.adder_inputA), 64'd0);
      check("rst_inB", 64'(bus.adder_inputB), 64'd0);
      check("rst_sub", 64'(bus.adder_add_sub_bit), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_ptr", 64'(bus.dbgRrPtr), 64'd0);
      bus.req_valid = '0;
      @(posedge clockIn);
      #1;
      resetN = 1'b1;

      // round-robin: everyone valid, (i+1.0)+1.0
      for (int i = 0; i < NUM_REQ; i++) setReq(i, opA[i], 32'h3F800000, 1'b0, rrExp[i]);
      grantLog.delete();
      n = 0;
      while (grantLog.size() < 5 && n < 40) begin
         @(posedge clockIn);
         #1;
         n++;
      end
      bus.req_valid = '0;
      check("rr_budget", 64'(n < 40), 64'd1);
      if (grantLog.size() >= 5) begin
         for (int k = 0; k < 5; k++) check("rr_grant", 64'(grantLog[k]), 64'(rrOrder[k]));
      end
      waitIdle("rr_drain");

      // single add with exact latency
      setReq(0, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000);
      @(negedge clockIn);
      check("add_ready", 64'(bus.req_ready), 64'h1);
      @(posedge clockIn);
      #1;
      bus.req_valid = '0;
      check("add_inA", 64'(bus.adder_inputA), 64'h3FC00000);
      check("add_inB", 64'(bus.adder_inputB), 64'h3F000000);
      check("add_sub", 64'(bus.adder_add_sub_bit), 64'd0);
      for (int k = 1; k <= ADDER_LATENCY; k++) begin
         @(posedge clockIn);
         #1;
         check("add_early", 64'(bus.rsp_valid), 64'd0);
      end
      @(posedge clockIn);
      #1;
      check("add_lat_valid", 64'(bus.rsp_valid), 64'h1);
      check("add_lat_data", 64'(bus.rsp_data), 64'h40000000);
      check("add_busy_hi", 64'(bus.busy), 64'd1);
      @(posedge clockIn);
      #1;
      check("add_pulse_end", 64'(bus.rsp_valid), 64'd0);
      check("add_busy_lo", 64'(bus.busy), 64'd0);

      // subtract routed to requester 2
      setReq(2, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000);
      @(negedge clockIn);
      check("sub_ready", 64'(bus.req_ready), 64'h4);
      @(posedge clockIn);
      #1;
      bus.req_valid = '0;
      check("sub_bit", 64'(bus.adder_add_sub_bit), 64'd1);
      waitIdle("sub_drain");

      // outstanding cap on requester 1
      a0 = acceptCount;
      r0 = resultCount;
      maxOut = 0;
      setReq(1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
      for (int k = 0; k < 12; k++) begin
         @(negedge clockIn);
         readyLog[k] = bus.req_ready[1];
         if (int'(bus.dbgOutstanding[7:4]) > maxOut) maxOut = int'(bus.dbgOutstanding[7:4]);
         @(posedge clockIn);
         #1;
      end
      bus.req_valid = '0;
      for (int k = 0; k < 12; k++) check("cap_ready_seq", 64'(readyLog[k]), 64'(capRdy[k]));
      waitIdle("cap_drain");
      check("cap_max_out", 64'(maxOut), 64'(MAX_OUT));
      check("cap_accepts", 64'(acceptCount - a0), 64'd10);
      check("cap_results", 64'(resultCount - r0), 64'(acceptCount - a0));

      // reset while three operations are in flight
      setReq(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
      repeat (3) @(posedge clockIn);
      #1;
      resetN = 1'b0;
      #1;
      check("mid_rst_inA", 64'(bus.adder_inputA), 64'd0);
      check("mid_rst_inB", 64'(bus.adder_inputB), 64'd0);
      check("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
      check("mid_rst_data", 64'(bus.rsp_data), 64'd0);
      check("mid_rst_busy", 64'(bus.busy), 64'd0);
      check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
      check("mid_rst_count", 64'(bus.dbgOutstanding), 64'd0);
      bus.req_valid = '0;
      @(posedge clockIn);
      #1;
      resetN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clockIn);
         #1;
         check("mid_rst_quiet", 64'(bus.rsp_valid), 64'd0);
      end
      r0 = resultCount;
      setReq(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
      @(negedge clockIn);
      check("fresh_ready", 64'(bus.req_ready), 64'h1);
      @(posedge clockIn);
      #1;
      bus.req_valid = '0;
      waitIdle("fresh_drain");
      check("fresh_results", 64'(resultCount - r0), 64'd1);

      // requester 3 on alternating cycles; pointer must hold across bubbles
      r0 = resultCount;
      for (int k = 0; k < 4; k++) begin
         setReq(3, opA[k], 32'h3F800000, 1'(k % 2), bubExp[k]);
         @(negedge clockIn);
         check("bub_ready", 64'(bus.req_ready), 64'h8);
         @(posedge clockIn);
         #1;
         bus.req_valid = '0;
         @(negedge clockIn);
         check("bub_ptr_idle", 64'(bus.dbgRrPtr), 64'd0);
         check("bub_ready_idle", 64'(bus.req_ready), 64'd0);
         @(posedge clockIn);
         #1;
      end
      waitIdle("bub_drain");
      check("bub_results", 64'(resultCount - r0), 64'd4);
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
